switch_event_queue: RTL and testbench
=====================================

Name: switch_event_queue

Overview:
Downstream consumer of the debounced switch bank. Takes the 18 debounced switch levels and their 1-cycle change pulses, and turns each change into a discrete event {switch index, new level}. Events are buffered in a small FIFO and presented on a valid/ready interface to the control FSM / display logic. Simultaneous changes are serialized lowest-index-first. No change is silently dropped without being flagged.

Parameters:
NUM_SW, 18, number of switch inputs (1..32)
FIFO_DEPTH, 8, event FIFO depth; power of 2, >= 2
TS_W, 16, timestamp width (used only with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sw_stable  input  NUM_SW  debounced switch levels
sw_changed  input  NUM_SW  1-cycle change pulse per bit, coincident with the new sw_stable value
evt_valid  output  1  head-of-FIFO event available
evt_ready  input  1  consumer accepts the head event
evt_index  output  5  switch index of the head event
evt_value  output  1  switch level of the head event
evt_time  output  TS_W  timestamp of the head event (only when SWITCH_EVT_TIMESTAMP_EN is defined)
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky: an intermediate change was coalesced
clear_overflow  input  1  clears overflow

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high. All state updates on posedge clk.
- Reset: pending mask=0, FIFO empty, fifo_count=0, overflow=0, evt_valid=0, evt_index=0, evt_value=0, evt_time=0, timestamp counter=0.
- Rst has priority over all other inputs. An in-flight event at reset is discarded.
- Pending mask, NUM_SW bits:
  - Update rule: pending_next = (pending & ~grant) | sw_changed.
  - A set from sw_changed wins over a same-cycle grant of the same bit. The result is a second event with the same level, which is allowed.
- Grant:
  - Condition: pending != 0 and fifo_count < FIFO_DEPTH, evaluated at the start of the cycle.
  - Selects the lowest-index set bit i. grant is one-hot on i.
  - Writes {i, sw_stable[i]} into the FIFO; the level is sampled in the grant cycle.
  - At most one write per cycle.
- Full FIFO: no grant, even if a pop occurs in the same cycle. The pending bits are held, so no index is lost.
- Overflow:
  - Set when sw_changed[i]=1 while pending[i]=1 and bit i is not granted that cycle (an intermediate transition was coalesced).
  - Set takes priority over a same-cycle clear_overflow.
  - Otherwise, clear_overflow=1 clears it next cycle.
- FIFO:
  - First-word-fall-through. evt_valid = (fifo_count != 0).
  - Pop when evt_valid & evt_ready. evt_ready with evt_valid=0 is ignored.
  - evt_index, evt_value and evt_time read 0 whenever evt_valid=0.
- fifo_count per cycle: +1 on write only, -1 on pop only, unchanged on both or neither.
- Read/write pointers: $clog2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH.
- Latency: sw_changed pulse at cycle N -> pending set at N+1 -> FIFO write at end of N+1 -> evt_valid=1 at N+2 when the FIFO was empty and no lower index was pending.
- Throughput: one event per cycle sustained.

Optional Feature:
- Macro: SWITCH_EVT_TIMESTAMP_EN.
- When defined:
  - A free-running TS_W-bit counter increments every cycle and wraps from 2^TS_W-1 to 0.
  - Each FIFO entry also stores the counter value of its write cycle.
  - The evt_time port exists and shows the head entry's stamp.
- When undefined:
  - No counter, no evt_time port, no timestamp storage.
  - FIFO entry width is 6 bits.
- All other behaviour is identical in both builds.

Test Plan:
- Reset check: rst=1 for 2 cycles with sw_changed=18'h3FFFF -> evt_valid=0, fifo_count=0, overflow=0, all outputs 0.
- Single event: sw_stable[5]=1, sw_changed=18'h00020 at cycle N, evt_ready=1 -> evt_valid=1 at N+2 with evt_index=5, evt_value=1. Popped the same cycle; fifo_count returns to 0.
- Simultaneous changes: sw_changed=18'h20011 in one cycle, evt_ready=1 -> events delivered in order index 0, 4, 17 on consecutive cycles.
- Backpressure and full: evt_ready=0, 10 distinct bits pulsed -> fifo_count saturates at 8 and 2 bits stay pending. Raise evt_ready -> all 10 events delivered, none lost, overflow=0.
- Coalescing: evt_ready=0, FIFO full, bit 3 pulsed twice while pending -> overflow=1. After draining, exactly one index-3 event with the latest sw_stable[3]. clear_overflow with no new collision -> overflow=0.
- Timestamps (macro defined): event written at counter 0xFFFF, next event written 1 cycle later -> evt_time 0xFFFF then 0x0000 (wrap).

Source files
------------

// File: rtl/switch_event_queue.sv
// Serializes debounced switch changes into {index, level} events through a FWFT FIFO.
// Define SWITCH_EVT_TIMESTAMP_EN to stamp each event with a free-running cycle counter (evt_time).
module switch_event_queue #(
   parameter int NUM_SW     = 18,
   parameter int FIFO_DEPTH = 8,
   parameter int TS_W       = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SW-1:0]             sw_stable,
   input  logic [NUM_SW-1:0]             sw_changed,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [4:0]                    evt_index,
   output logic                          evt_value,
`ifdef SWITCH_EVT_TIMESTAMP_EN
   output logic [TS_W-1:0]               evt_time,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   input  logic                          clear_overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
`ifdef SWITCH_EVT_TIMESTAMP_EN
   localparam int EW = 6 + TS_W;
`else
   localparam int EW = 6;
`endif

   logic [NUM_SW-1:0] r_pending;
   logic [EW-1:0]     r_mem [FIFO_DEPTH];
   logic [PW-1:0]     r_wptr, r_rptr;
   logic [CW-1:0]     r_count;
   logic              r_overflow;
`ifdef SWITCH_EVT_TIMESTAMP_EN
   logic [TS_W-1:0]   r_ts;
`endif

   logic [NUM_SW-1:0] w_first;
   logic [NUM_SW-1:0] w_grant;
   logic [4:0]        w_gidx;
   logic              w_gval;
   logic              w_found;
   logic              w_wr;
   logic              w_pop;
   logic [EW-1:0]     w_wdata;
   logic [EW-1:0]     w_head;

   // Lowest-index pending bit wins; only one event is written per cycle.
   always_comb begin
      w_first = '0;
      w_gidx  = '0;
      w_gval  = 1'b0;
      w_found = 1'b0;
      for (int i = 0; i < NUM_SW; i++) begin
         if (r_pending[i] && !w_found) begin
            w_found    = 1'b1;
            w_first[i] = 1'b1;
            w_gidx     = 5'(i);
            w_gval     = sw_stable[i];
         end
      end
   end

   // A full FIFO blocks the grant even when a pop happens this cycle.
   assign w_wr    = w_found && (r_count < DEPTH_C);
   assign w_grant = w_wr ? w_first : '0;
   assign w_pop   = (r_count != '0) && evt_ready;

`ifdef SWITCH_EVT_TIMESTAMP_EN
   assign w_wdata = {r_ts, w_gidx, w_gval};
`else
   assign w_wdata = {w_gidx, w_gval};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending  <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_pending <= (r_pending & ~w_grant) | sw_changed;
         if (w_wr)  r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A change landing on a still-pending bit means a transition was coalesced.
         if (|(sw_changed & r_pending & ~w_grant))
            r_overflow <= 1'b1;
         else if (clear_overflow)
            r_overflow <= 1'b0;
      end
   end

`ifdef SWITCH_EVT_TIMESTAMP_EN
   always_ff @(posedge clk) begin
      if (rst) r_ts <= '0;
      else     r_ts <= r_ts + 1'b1;
   end
`endif

   // Storage needs no reset: outputs are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (!rst && w_wr) r_mem[r_wptr] <= w_wdata;
   end

   assign w_head     = r_mem[r_rptr];
   assign evt_valid  = (r_count != '0);
   assign evt_value  = evt_valid ? w_head[0]   : 1'b0;
   assign evt_index  = evt_valid ? w_head[5:1] : 5'd0;
`ifdef SWITCH_EVT_TIMESTAMP_EN
   assign evt_time   = evt_valid ? w_head[EW-1:6] : '0;
`endif
   assign fifo_count = r_count;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_switch_event_queue.sv
// Bench for switch_event_queue: directed scenarios plus random traffic against a queue-based model.
module tb_switch_event_queue;
   localparam int NSW = 18;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [17:0] sw_stable = '0;
   logic [17:0] sw_changed = '0;
   logic        evt_valid, evt_value, overflow;
   logic        evt_ready = 1'b0;
   logic        clear_overflow = 1'b0;
   logic [4:0]  evt_index;
   logic [3:0]  fifo_count;
`ifdef SWITCH_EVT_TIMESTAMP_EN
   logic [15:0] evt_time;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {int idx; bit val; logic [15:0] ts;} ev_t;
   ev_t         mq[$];
   bit [17:0]   m_pend = '0;
   bit          m_ov = 1'b0;
   logic [15:0] m_ts = '0;

   always #5 clk = ~clk;

   switch_event_queue #(.NUM_SW(18), .FIFO_DEPTH(8), .TS_W(16)) dut (
      .clk(clk), .rst(rst), .sw_stable(sw_stable), .sw_changed(sw_changed),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_index(evt_index),
      .evt_value(evt_value),
`ifdef SWITCH_EVT_TIMESTAMP_EN
      .evt_time(evt_time),
`endif
      .fifo_count(fifo_count), .overflow(overflow), .clear_overflow(clear_overflow)
   );

   // Advance one clock; the model applies the cycle's rules to the inputs seen at the edge.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         mq.delete(); m_pend = '0; m_ov = 1'b0; m_ts = '0;
      end else begin
         int  g = -1;
         bit  coll = 1'b0;
         ev_t e;
         if (m_pend != 0 && mq.size() < DEPTH)
            for (int i = NSW-1; i >= 0; i--) if (m_pend[i]) g = i;
         for (int i = 0; i < NSW; i++)
            if (sw_changed[i] && m_pend[i] && i != g) coll = 1'b1;
         if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
         if (g >= 0) begin
            e.idx = g; e.val = sw_stable[g]; e.ts = m_ts;
            mq.push_back(e);
            m_pend[g] = 1'b0;
         end
         m_pend |= sw_changed;
         if (coll) m_ov = 1'b1;
         else if (clear_overflow) m_ov = 1'b0;
         m_ts = m_ts + 16'd1;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; sw_changed = 18'h3FFFF; sw_stable = 18'h3FFFF;
      tick(); tick();
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      checks++; if (evt_index !== 5'd0 || evt_value !== 1'b0) begin errors++; $display("FAIL reset_outputs: got idx=%0d val=%b want 0/0", evt_index, evt_value); end
`ifdef SWITCH_EVT_TIMESTAMP_EN
      checks++; if (evt_time !== 16'd0) begin errors++; $display("FAIL reset_time: got %0h want 0", evt_time); end
`endif
      rst = 1'b0; sw_changed = '0;
      tick(); tick();
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_discard: got valid=%b want 0", evt_valid); end
   endtask

   task automatic test_single();
      sw_stable = 18'h00020; sw_changed = 18'h00020; evt_ready = 1'b1;
      tick(); sw_changed = '0;
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_n1: got valid=%b want 0", evt_valid); end
      tick();
      checks++; if (evt_valid !== 1'b1 || evt_index !== 5'd5 || evt_value !== 1'b1)
         begin errors++; $display("FAIL single_n2: got v=%b idx=%0d val=%b want 1/5/1", evt_valid, evt_index, evt_value); end
      checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d want 1", fifo_count); end
      tick();
      checks++; if (fifo_count !== 4'd0 || evt_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got count=%0d v=%b want 0/0", fifo_count, evt_valid); end
   endtask

   task automatic test_simultaneous();
      int  ei[3] = '{0, 4, 17};
      bit  ev[3] = '{1'b1, 1'b0, 1'b1};
      sw_stable = 18'h20001; sw_changed = 18'h20011; evt_ready = 1'b1;
      tick(); sw_changed = '0;
      tick();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (evt_valid !== 1'b1 || evt_index !== 5'(ei[k]) || evt_value !== ev[k])
            begin errors++; $display("FAIL simul_order[%0d]: got v=%b idx=%0d val=%b want 1/%0d/%b", k, evt_valid, evt_index, evt_value, ei[k], ev[k]); end
         tick();
      end
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL simul_empty: got valid=%b want 0", evt_valid); end
   endtask

   task automatic test_full();
      int got[$];
      evt_ready = 1'b0; sw_stable = '0; sw_changed = 18'h003FF;
      tick(); sw_changed = '0;
      repeat (12) tick();
      checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", fifo_count); end
      checks++; if (evt_valid !== 1'b1 || evt_index !== 5'd0) begin errors++; $display("FAIL full_head: got v=%b idx=%0d want 1/0", evt_valid, evt_index); end
      evt_ready = 1'b1;
      for (int c = 0; c < 40 && got.size() < 10; c++) begin
         if (evt_valid) got.push_back(int'(evt_index));
         tick();
      end
      checks++; if (got.size() != 10) begin errors++; $display("FAIL full_drain_n: got %0d events want 10", got.size()); end
      for (int k = 0; k < got.size(); k++) begin
         checks++; if (got[k] != k) begin errors++; $display("FAIL full_order[%0d]: got %0d want %0d", k, got[k], k); end
      end
      checks++; if (fifo_count !== 4'd0 || overflow !== 1'b0) begin errors++; $display("FAIL full_end: got count=%0d ov=%b want 0/0", fifo_count, overflow); end
   endtask

   task automatic test_coalesce();
      int n3 = 0, tot = 0;
      bit v3 = 1'b0;
      evt_ready = 1'b0; sw_stable = '0; sw_changed = 18'h3FC00;
      tick(); sw_changed = '0;
      repeat (10) tick();
      checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL coal_full: got %0d want 8", fifo_count); end
      sw_stable[3] = 1'b1; sw_changed = 18'h00008;
      tick();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL coal_first: got ov=%b want 0", overflow); end
      sw_stable[3] = 1'b0;
      tick();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL coal_second: got ov=%b want 1", overflow); end
      sw_stable[3] = 1'b1; clear_overflow = 1'b1;
      tick(); sw_changed = '0; clear_overflow = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL coal_set_beats_clear: got ov=%b want 1", overflow); end
      evt_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (evt_valid) begin
            tot++;
            if (evt_index == 5'd3) begin n3++; v3 = evt_value; end
         end
         tick();
      end
      checks++; if (tot != 9) begin errors++; $display("FAIL coal_total: got %0d want 9", tot); end
      checks++; if (n3 != 1 || v3 !== 1'b1) begin errors++; $display("FAIL coal_idx3: got n=%0d val=%b want 1/1", n3, v3); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL coal_sticky: got ov=%b want 1", overflow); end
      clear_overflow = 1'b1;
      tick(); clear_overflow = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL coal_clear: got ov=%b want 0", overflow); end
   endtask

   task automatic test_random();
      bit         ev;
      logic [4:0] ei;
      bit         eval;
      for (int c = 0; c < 500; c++) begin
         sw_stable      = 18'($urandom);
         sw_changed     = ($urandom_range(0, 5) == 0) ? 18'($urandom & $urandom) : 18'd0;
         evt_ready      = ($urandom_range(0, 3) != 0);
         clear_overflow = ($urandom_range(0, 7) == 0);
         tick();
         ev   = (mq.size() > 0);
         ei   = ev ? 5'(mq[0].idx) : 5'd0;
         eval = ev ? mq[0].val : 1'b0;
         checks++; if (evt_valid !== ev) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", c, evt_valid, ev); end
         checks++; if (evt_index !== ei || evt_value !== eval)
            begin errors++; $display("FAIL rnd_head@%0d: got %0d/%b want %0d/%b", c, evt_index, evt_value, ei, eval); end
         checks++; if (fifo_count !== 4'(mq.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, fifo_count, mq.size()); end
         checks++; if (overflow !== m_ov) begin errors++; $display("FAIL rnd_ov@%0d: got %b want %b", c, overflow, m_ov); end
`ifdef SWITCH_EVT_TIMESTAMP_EN
         checks++; if (evt_time !== (ev ? mq[0].ts : 16'd0)) begin errors++; $display("FAIL rnd_time@%0d: got %0h", c, evt_time); end
`endif
      end
      sw_changed = '0; clear_overflow = 1'b0; evt_ready = 1'b1;
      repeat (40) tick();
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rnd_drain: got %0d want 0", fifo_count); end
   endtask

`ifdef SWITCH_EVT_TIMESTAMP_EN
   task automatic test_timestamp();
      evt_ready = 1'b0; sw_changed = '0; sw_stable = '0;
      for (int c = 0; c < 70000 && m_ts != 16'hFFFE; c++) tick();
      checks++; if (m_ts != 16'hFFFE) begin errors++; $display("FAIL ts_wait: timed out at %0h", m_ts); end
      sw_changed = 18'h00006;
      tick(); sw_changed = '0;
      tick(); tick(); tick();
      checks++; if (evt_time !== 16'hFFFF || evt_index !== 5'd1) begin errors++; $display("FAIL ts_first: got %0h idx=%0d want ffff/1", evt_time, evt_index); end
      evt_ready = 1'b1;
      tick();
      checks++; if (evt_time !== 16'h0000 || evt_index !== 5'd2) begin errors++; $display("FAIL ts_wrap: got %0h idx=%0d want 0/2", evt_time, evt_index); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_full();
      test_coalesce();
      test_random();
`ifdef SWITCH_EVT_TIMESTAMP_EN
      test_timestamp();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
